// File: rtl/sata_pkg.sv
// sata_pkg: FIS type codes, command classes, sequencer states and opcode decode
package sata_pkg;
  localparam logic [7:0] FIS_H2D = 8'h27;
  localparam logic [7:0] FIS_D2H = 8'h34;
  localparam logic [7:0] FIS_DMA_ACT = 8'h39;
  localparam logic [7:0] FIS_DATA = 8'h46;
  localparam logic [7:0] FIS_PIO = 8'h5F;
  typedef enum logic [2:0] {
    CLS_NODATA,
    CLS_PIO_IN,
    CLS_PIO_OUT,
    CLS_DMA_IN,
    CLS_DMA_OUT
  } cmd_class_t;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_CMD,
    ST_WAIT_FIS,
    ST_SEND_DATA,
    ST_RECV_DATA,
    ST_DONE
  } state_t;
  function automatic cmd_class_t cmd_class(input logic [7:0] op);
    case (op)
      8'h20, 8'h24, 8'h29, 8'hC4, 8'hEC: return CLS_PIO_IN;
      8'h30, 8'h34, 8'h39, 8'hC5: return CLS_PIO_OUT;
      8'h25, 8'hC8: return CLS_DMA_IN;
      8'h35, 8'hCA: return CLS_DMA_OUT;
      default: return CLS_NODATA;
    endcase
  endfunction
endpackage

// File: rtl/sata_fis_txmux.sv
// sata_fis_txmux: picks the TX word (H2D register word, Data FIS header or write payload) and its last flag
module sata_fis_txmux
  import sata_pkg::*;
(
  input  logic        data_phase,
  input  logic [15:0] idx,
  input  logic [15:0] n,
  input  logic [7:0]  cmd,
  input  logic [47:0] lba,
  input  logic [15:0] count,
  input  logic [31:0] wr_data,
  output logic [31:0] m_data,
  output logic        m_last
);
  logic [31:0] h2d;
  always_comb begin
    h2d = idx == 16'd0 ? {FIS_H2D, 8'h80, cmd, 8'h00} :
          idx == 16'd1 ? {lba[7:0], lba[15:8], lba[23:16], 8'h40} :
          idx == 16'd2 ? {lba[31:24], lba[39:32], lba[47:40], 8'h00} :
          idx == 16'd3 ? {count[7:0], count[15:8], 16'h0000} : 32'h0;
    m_data = data_phase ? (idx == 16'd0 ? {FIS_DATA, 24'h0} : wr_data) : h2d;
    m_last = data_phase ? idx == n : idx == 16'd4;
  end
endmodule

// File: rtl/sata_cmd_seq.sv
// sata_cmd_seq: host ATA command sequencer (H2D FIS out, device FIS handling).
// Define SATA_SEQ_TIMEOUT_EN to add a watchdog that ends a stalled command with status FF.
module sata_cmd_seq
  import sata_pkg::*;
#(
  parameter int MAX_FIS_WORDS = 2048,
  parameter int WORDS_PER_SECTOR = 128,
  parameter int TIMEOUT_CYCLES = 2**20
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [7:0]  i_cmd,
  input  logic [47:0] i_lba,
  input  logic [15:0] i_count,
  output logic        o_done,
  output logic [7:0]  o_status,
  output logic [7:0]  o_error,
  output logic        o_err,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  output logic        m_last,
  input  logic        s_valid,
  input  logic [31:0] s_data,
  input  logic        s_last,
  input  logic        s_abort,
  input  logic        i_wr_valid,
  output logic        o_wr_ready,
  input  logic [31:0] i_wr_data,
  output logic        o_rd_valid,
  output logic [31:0] o_rd_data,
  output logic        o_rd_last
);
  state_t state;
  cmd_class_t cls;
  logic [7:0] cmd, ftype, status, error, e_status, typ;
  logic [47:0] lba;
  logic [15:0] count, idx, n, dma_n;
  logic [31:0] remain, remain_start, mux_data;
  logic [2:0] pos, cur;
  logic in_frame, err, tx_hs, payload, mux_last;
  assign o_cmd_ready = !i_reset && state == ST_IDLE;
  assign payload = state == ST_SEND_DATA && idx != 16'd0;
  assign m_valid = !i_reset && (state == ST_SEND_CMD || (state == ST_SEND_DATA && (idx == 16'd0 || i_wr_valid)));
  assign o_wr_ready = !i_reset && payload && m_ready;
  assign tx_hs = m_valid && m_ready;
  assign m_data = m_valid ? mux_data : 32'h0;
  assign m_last = m_valid && mux_last;
  assign o_done = state == ST_DONE;
  assign o_err = o_done && (err || status[0]);
  assign o_status = status;
  assign o_error = error;
  assign cur = in_frame ? pos : 3'd0;
  assign typ = in_frame ? ftype : s_data[31:24];
  assign dma_n = remain > 32'(MAX_FIS_WORDS) ? 16'(MAX_FIS_WORDS) : remain[15:0];
  sata_fis_txmux u_txmux (
    .data_phase(state == ST_SEND_DATA),
    .idx(idx),
    .n(n),
    .cmd(cmd),
    .lba(lba),
    .count(count),
    .wr_data(i_wr_data),
    .m_data(mux_data),
    .m_last(mux_last)
  );
`ifdef SATA_SEQ_TIMEOUT_EN
  logic [31:0] wd;
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYCLES;
`endif
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= ST_IDLE;
      cls <= CLS_NODATA;
      {cmd, lba, count, ftype, status, error, e_status} <= '0;
      {remain, remain_start, idx, n, pos, in_frame, err} <= '0;
      {o_rd_valid, o_rd_data, o_rd_last} <= '0;
`ifdef SATA_SEQ_TIMEOUT_EN
      wd <= '0;
`endif
    end else begin
      o_rd_valid <= 1'b0;
      o_rd_last <= 1'b0;
      case (state)
        ST_IDLE: if (i_cmd_valid) begin
          cmd <= i_cmd;
          lba <= i_lba;
          count <= i_count;
          cls <= cmd_class(i_cmd);
          remain <= 32'({i_count == 16'd0, i_count}) * 32'(WORDS_PER_SECTOR);
          {idx, err, status, error, e_status} <= '0;
          state <= ST_SEND_CMD;
        end
        ST_SEND_CMD: begin
          if (s_valid) err <= 1'b1;
          if (tx_hs) idx <= idx == 16'd4 ? 16'd0 : idx + 16'd1;
          if (tx_hs && idx == 16'd4) state <= ST_WAIT_FIS;
        end
        ST_SEND_DATA: begin
          if (s_valid) err <= 1'b1;
          if (tx_hs) begin
            idx <= idx == n ? 16'd0 : idx + 16'd1;
            if (payload && remain == 32'd0) err <= 1'b1;
            else if (payload) remain <= remain - 32'd1;
            if (idx == n) state <= ST_WAIT_FIS;
          end
        end
        ST_WAIT_FIS: begin
          if (s_abort) begin
            in_frame <= 1'b0;
            remain <= remain_start;
          end else if (s_valid) begin
            in_frame <= !s_last;
            pos <= cur == 3'd7 ? cur : cur + 3'd1;
            if (!in_frame) begin
              ftype <= s_data[31:24];
              remain_start <= remain;
            end
            if (typ == FIS_D2H && cur == 3'd0) {status, error} <= s_data[15:0];
            if (typ == FIS_PIO && cur == 3'd3) e_status <= s_data[31:24];
            if (typ == FIS_PIO && cur == 3'd4) n <= {s_data[23:16], s_data[31:24]} >> 2;
            if (typ == FIS_DATA && (cls == CLS_PIO_OUT || cls == CLS_DMA_OUT)) err <= 1'b1;
            if (typ == FIS_DATA && !s_last) state <= ST_RECV_DATA;
            if (s_last && typ == FIS_D2H) state <= ST_DONE;
            // A DMA Activate for a command with no outgoing data is flagged but not acted on
            if (s_last && typ == FIS_DMA_ACT && cls != CLS_DMA_OUT) err <= 1'b1;
            if (s_last && typ == FIS_DMA_ACT && cls == CLS_DMA_OUT) begin
              n <= dma_n;
              state <= ST_SEND_DATA;
            end
            if (s_last && typ == FIS_PIO && cls == CLS_PIO_OUT) state <= ST_SEND_DATA;
          end
        end
        ST_RECV_DATA: begin
          if (s_abort) begin
            in_frame <= 1'b0;
            remain <= remain_start;
            state <= ST_WAIT_FIS;
          end else if (s_valid) begin
            o_rd_valid <= 1'b1;
            o_rd_data <= s_data;
            o_rd_last <= s_last;
            if (remain == 32'd0) err <= 1'b1;
            else remain <= remain - 32'd1;
            if (s_last) begin
              in_frame <= 1'b0;
              state <= cls == CLS_PIO_IN && remain == 32'd1 ? ST_DONE : ST_WAIT_FIS;
              if (cls == CLS_PIO_IN && remain == 32'd1) status <= e_status;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
`ifdef SATA_SEQ_TIMEOUT_EN
      // Entering WAIT_FIS always coincides with a handshake or abort, so those clears cover it
      wd <= state == ST_IDLE || tx_hs || s_valid || s_abort ? 32'd0 : wd + 32'd1;
      if (state != ST_IDLE && state != ST_DONE && wd >= 32'(TIMEOUT_CYCLES - 1)) begin
        state <= ST_DONE;
        status <= 8'hFF;
        err <= 1'b1;
        in_frame <= 1'b0;
      end
`endif
    end
  end
endmodule

// File: tb/tb_sata_cmd_seq.sv
// tb_sata_cmd_seq: table-driven and scoreboard bench for sata_cmd_seq
module tb_sata_cmd_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_cmd_valid, o_cmd_ready, o_done, o_err;
  logic [7:0] i_cmd, o_status, o_error;
  logic [47:0] i_lba;
  logic [15:0] i_count;
  logic m_valid, m_ready, m_last, s_valid, s_last, s_abort;
  logic [31:0] m_data, s_data, i_wr_data, o_rd_data;
  logic i_wr_valid, o_wr_ready, o_rd_valid, o_rd_last;
  always #5 clk = ~clk;

  sata_cmd_seq #(.TIMEOUT_CYCLES(64)) dut (
    .i_clk(clk), .i_reset(rst), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd(i_cmd), .i_lba(i_lba), .i_count(i_count), .o_done(o_done), .o_status(o_status),
    .o_error(o_error), .o_err(o_err), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_abort(s_abort),
    .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready), .i_wr_data(i_wr_data),
    .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data), .o_rd_last(o_rd_last)
  );

  typedef struct packed {logic [31:0] d; logic l;} word_t;
  typedef struct {
    logic [7:0] op; logic [47:0] lba; logic [15:0] cnt;
    logic [31:0] w0, w1, w2, w3;
    logic [7:0] st, er; logic e;
  } vec_t;
  word_t exp_tx[$], exp_rd[$];
  word_t tw, rw;
  vec_t tbl[3];
  int checks = 0, errors = 0, done_cnt = 0, rd_cnt = 0, rd_last_cnt = 0;
  logic [7:0] d_status = 8'h0, d_error = 8'h0;
  logic d_err = 1'b0, prev_done = 1'b0;
  logic [31:0] wr_cnt = 32'h0;
  assign i_wr_data = 32'hA000_0000 + wr_cnt;
  always @(posedge clk) if (o_wr_ready && i_wr_valid) wr_cnt <= wr_cnt + 32'd1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid && m_ready) begin
      if (exp_tx.size() == 0) check("tx_extra", 64'(m_data), 64'hFFFF_FFFF_FFFF_FFFF);
      else begin
        tw = exp_tx.pop_front();
        check("tx_word", {31'd0, m_last, m_data}, {31'd0, tw.l, tw.d});
      end
    end
    if (o_rd_valid) begin
      rd_cnt++;
      if (o_rd_last) rd_last_cnt++;
      if (exp_rd.size() == 0) check("rd_extra", 64'(o_rd_data), 64'hFFFF_FFFF_FFFF_FFFF);
      else begin
        rw = exp_rd.pop_front();
        check("rd_word", {31'd0, o_rd_last, o_rd_data}, {31'd0, rw.l, rw.d});
      end
    end
    if (o_done) begin
      done_cnt++;
      d_status = o_status;
      d_error = o_error;
      d_err = o_err;
      check("done_one_cycle", {63'd0, prev_done}, 64'd0);
    end
    prev_done = o_done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push_tx(input logic [31:0] d, input logic l);
    exp_tx.push_back({d, l});
  endtask
  task automatic issue(input logic [7:0] op, input logic [47:0] lba, input logic [15:0] cnt,
                       input logic [31:0] w0, w1, w2, w3);
    int i = 0;
    while (!o_cmd_ready && i < 100) begin tick(); i++; end
    push_tx(w0, 0); push_tx(w1, 0); push_tx(w2, 0); push_tx(w3, 0); push_tx(32'h0, 1);
    i_cmd = op; i_lba = lba; i_count = cnt; i_cmd_valid = 1'b1;
    tick();
    i_cmd_valid = 1'b0;
  endtask
  task automatic wait_tx(input bit rnd);
    int i = 0;
    while (exp_tx.size() != 0 && i < 2000) begin
      if (rnd) m_ready = 1'($urandom_range(0, 1));
      tick();
      i++;
    end
    m_ready = 1'b1;
    check("tx_drained", 64'(exp_tx.size()), 64'd0);
  endtask
  task automatic s_word(input logic [31:0] d, input logic l);
    s_valid = 1'b1; s_data = d; s_last = l;
    tick();
    s_valid = 1'b0; s_last = 1'b0;
  endtask
  task automatic abort();
    s_abort = 1'b1;
    tick();
    s_abort = 1'b0;
  endtask
  task automatic d2h(input logic [7:0] st, input logic [7:0] er);
    s_word({8'h34, 8'h40, st, er}, 0);
    repeat (3) s_word(32'h0, 0);
    s_word(32'h0, 1);
  endtask
  task automatic data_frame(input int n, input logic [31:0] base, input int stop_at);
    s_word(32'h4600_0000, 0);
    for (int k = 0; k < n; k++) begin
      if (k == stop_at) begin abort(); return; end
      exp_rd.push_back({base + 32'(k), k == n - 1});
      s_word(base + 32'(k), k == n - 1);
    end
  endtask
  task automatic push_payload(input logic [31:0] base, input int n);
    push_tx(32'h4600_0000, 0);
    for (int k = 0; k < n; k++) push_tx(32'hA000_0000 + base + 32'(k), k == n - 1);
  endtask
  task automatic wait_done(input int start, input int bound);
    int i = 0;
    while (done_cnt == start && i < bound) begin tick(); i++; end
    check("done_seen", 64'(done_cnt), 64'(start + 1));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    int s, r0, l0;
    logic [31:0] base;
    tbl[0] = '{8'hE7, 48'h0, 16'h0, 32'h2780E700, 32'h00000040, 32'h0, 32'h0, 8'h50, 8'h00, 1'b0};
    tbl[1] = '{8'hE0, 48'h0102_0304_0506, 16'h0A0B, 32'h2780E000, 32'h06050440, 32'h03020100,
               32'h0B0A0000, 8'h51, 8'h04, 1'b1};
    tbl[2] = '{8'hFF, 48'hABCD_EF12_3456, 16'hFFFF, 32'h2780FF00, 32'h56341240, 32'hEFCDAB00,
               32'hFFFF0000, 8'h40, 8'h00, 1'b0};
    {i_cmd_valid, i_cmd, i_lba, i_count, s_valid, s_data, s_last, s_abort} = '0;
    m_ready = 1'b1;
    i_wr_valid = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("reset_cmd_ready", 64'(o_cmd_ready), 64'd0);
    check("reset_m_valid", 64'(m_valid), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_reset_cmd_ready", 64'(o_cmd_ready), 64'd1);
    check("post_reset_outputs", {o_done, o_err, o_rd_valid, o_status, o_error}, 64'd0);
    tick();

    for (int i = 0; i < 3; i++) begin
      s = done_cnt;
      issue(tbl[i].op, tbl[i].lba, tbl[i].cnt, tbl[i].w0, tbl[i].w1, tbl[i].w2, tbl[i].w3);
      wait_tx(0);
      d2h(tbl[i].st, tbl[i].er);
      wait_done(s, 20);
      check("tbl_status", 64'(d_status), 64'(tbl[i].st));
      check("tbl_error", 64'(d_error), 64'(tbl[i].er));
      check("tbl_err", 64'(d_err), 64'(tbl[i].e));
    end

    s = done_cnt;
    issue(8'hE7, 48'h0, 16'h0, 32'h2780E700, 32'h40, 32'h0, 32'h0);
    s_word(32'hA100_0000, 1);
    wait_tx(0);
    d2h(8'h50, 8'h00);
    wait_done(s, 20);
    check("stray_rx_err", 64'(d_err), 64'd1);

    s = done_cnt;
    issue(8'hE7, 48'h0, 16'h0, 32'h2780E700, 32'h40, 32'h0, 32'h0);
    wait_tx(0);
    s_word(32'h3900_0000, 1);
    d2h(8'h50, 8'h00);
    wait_done(s, 20);
    check("dma_act_nodata_err", 64'(d_err), 64'd1);

    s = done_cnt;
    issue(8'hCA, 48'h1234, 16'd1, 32'h2780CA00, 32'h34120040, 32'h0, 32'h01000000);
    wait_tx(1);
    base = wr_cnt;
    s_word(32'h3900_0000, 1);
    push_payload(base, 128);
    wait_tx(1);
    d2h(8'h50, 8'h00);
    wait_done(s, 20);
    check("dma_wr_status", 64'(d_status), 64'h50);
    check("dma_wr_err", 64'(d_err), 64'd0);
    check("dma_wr_words", 64'(wr_cnt - base), 64'd128);

    s = done_cnt; r0 = rd_cnt; l0 = rd_last_cnt;
    issue(8'hC8, 48'h0, 16'd2, 32'h2780C800, 32'h40, 32'h0, 32'h02000000);
    wait_tx(0);
    data_frame(128, 32'hB000_0000, -1);
    data_frame(128, 32'hB100_0000, -1);
    d2h(8'h50, 8'h00);
    wait_done(s, 20);
    check("dma_rd_count", 64'(rd_cnt - r0), 64'd256);
    check("dma_rd_lasts", 64'(rd_last_cnt - l0), 64'd2);
    check("dma_rd_err", 64'(d_err), 64'd0);
    check("dma_rd_drained", 64'(exp_rd.size()), 64'd0);

    s = done_cnt; r0 = rd_cnt; l0 = rd_last_cnt;
    issue(8'hEC, 48'h0, 16'd1, 32'h2780EC00, 32'h40, 32'h0, 32'h01000000);
    wait_tx(0);
    s_word(32'h5F20_5000, 0);
    s_word(32'h0, 0);
    s_word(32'h0, 0);
    s_word(32'h5000_0000, 0);
    s_word(32'h0002_0000, 1);
    data_frame(128, 32'hC000_0000, 50);
    data_frame(128, 32'hC100_0000, -1);
    wait_done(s, 10);
    check("pio_in_status", 64'(d_status), 64'h50);
    check("pio_in_err", 64'(d_err), 64'd0);
    check("pio_in_count", 64'(rd_cnt - r0), 64'd178);
    check("pio_in_lasts", 64'(rd_last_cnt - l0), 64'd1);
    check("pio_in_drained", 64'(exp_rd.size()), 64'd0);

    s = done_cnt;
    issue(8'hCA, 48'h0, 16'd1, 32'h2780CA00, 32'h40, 32'h0, 32'h01000000);
    wait_tx(0);
    s_word(32'hA100_0000, 0);
    s_word(32'h0, 0);
    abort();
    repeat (4) begin
      @(negedge clk);
      check("abort_m_valid_low", 64'(m_valid), 64'd0);
      tick();
    end
    base = wr_cnt;
    s_word(32'h3900_0000, 1);
    push_payload(base, 128);
    wait_tx(0);
    d2h(8'h50, 8'h00);
    wait_done(s, 20);
    check("abort_dma_out_err", 64'(d_err), 64'd0);

    issue(8'hCA, 48'h0, 16'd1, 32'h2780CA00, 32'h40, 32'h0, 32'h01000000);
    wait_tx(0);
    base = wr_cnt;
    s_word(32'h3900_0000, 1);
    push_payload(base, 128);
    for (int i = 0; i < 500 && wr_cnt - base < 32'd10; i++) tick();
    check("reset_at_word10", 64'(wr_cnt - base), 64'd10);
    rst = 1'b1;
    @(negedge clk);
    check("in_reset_m_valid", 64'(m_valid), 64'd0);
    check("in_reset_cmd_ready", 64'(o_cmd_ready), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    exp_tx.delete();
    @(negedge clk);
    check("after_reset_m_valid", 64'(m_valid), 64'd0);
    check("after_reset_cmd_ready", 64'(o_cmd_ready), 64'd1);
    tick();

`ifdef SATA_SEQ_TIMEOUT_EN
    s = done_cnt;
    issue(8'hE7, 48'h0, 16'h0, 32'h2780E700, 32'h40, 32'h0, 32'h0);
    wait_tx(0);
    wait_done(s, 300);
    check("timeout_status", 64'(d_status), 64'hFF);
    check("timeout_err", 64'(d_err), 64'd1);
`endif

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
